// File: rtl/mhd_pkg.sv
// Shared types and constants for the Hamming-distance error monitor and the miter generator.
package mhd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int WIDTH_DEF = 33;
    localparam int MHD_DEF   = 8;

    // Bits needed to hold a popcount of a w-bit word (0..w inclusive).
    function automatic int hd_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational adder-tree popcount; the input is zero-padded to a power of two and reduced pairwise.
module mhd_popcount
    import mhd_pkg::*;
#(
    parameter int  WIDTH = WIDTH_DEF,
    localparam int HD_W  = hd_width(WIDTH)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [HD_W-1:0]  count_o
);

    localparam int NP = 1 << $clog2(WIDTH);

    logic [NP-1:0]   padded;
    logic [HD_W-1:0] tree [NP];

    always_comb begin
        padded = NP'(bits_i);
        for (int i = 0; i < NP; i++) begin
            tree[i] = HD_W'(padded[i]);
        end
        // In-place pairwise reduction: each level halves the number of live partial sums.
        for (int step = 1; step < NP; step = step * 2) begin
            for (int i = 0; i < NP; i = i + 2 * step) begin
                tree[i] = tree[i] + tree[i + step];
            end
        end
        count_o = tree[0];
    end

endmodule

// File: rtl/mhd_err_monitor.sv
// Streaming Hamming-distance monitor: 3-stage pipeline (xor, popcount, stats) under a window FSM.
module mhd_err_monitor
    import mhd_pkg::*;
#(
    parameter int  WIDTH   = WIDTH_DEF,
    parameter int  MHD     = MHD_DEF,
    parameter int  NSAMP_W = 16,
    parameter int  CNT_W   = 16,
    localparam int HD_W    = hd_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NSAMP_W-1:0] num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   viol_cnt,
    output logic [HD_W-1:0]    max_hd,
    output logic               first_viol_vld,
    output logic [NSAMP_W-1:0] first_viol_idx
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e               state_q, state_d;
    logic [NSAMP_W-1:0]   nsamp_q, nsamp_d;
    logic [NSAMP_W-1:0]   acc_cnt_q, acc_cnt_d, acc_inc;
    logic [CNT_W-1:0]     viol_q, viol_d;
    logic [HD_W-1:0]      max_q, max_d;
    logic                 fvld_q, fvld_d;
    logic [NSAMP_W-1:0]   fidx_q, fidx_d;
    logic                 accept;

    logic                 vld_p1_q, vld_p2_q;
    logic [WIDTH-1:0]     diff_p1_q;
    logic [NSAMP_W-1:0]   idx_p1_q, idx_p2_q;
    logic [HD_W-1:0]      hd_p1, hd_p2_q;

    assign in_ready = (state_q == RUN) && (acc_cnt_q < nsamp_q);
    assign accept   = in_valid && in_ready;
    assign acc_inc  = acc_cnt_q + 1'b1;

    mhd_popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits_i  (diff_p1_q),
        .count_o (hd_p1)
    );

    always_comb begin
        state_d   = state_q;
        nsamp_d   = nsamp_q;
        acc_cnt_d = acc_cnt_q;
        viol_d    = viol_q;
        max_d     = max_q;
        fvld_d    = fvld_q;
        fidx_d    = fidx_q;

        // S3: fold a valid popcount into the window statistics
        if (vld_p2_q) begin
            if (int'(hd_p2_q) > MHD) begin
                viol_d = sat_inc(viol_q);
                if (!fvld_q) begin
                    fvld_d = 1'b1;
                    fidx_d = idx_p2_q;
                end
            end
            if (hd_p2_q > max_q) begin
                max_d = hd_p2_q;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    nsamp_d   = num_samples;
                    acc_cnt_d = '0;
                    viol_d    = '0;
                    max_d     = '0;
                    fvld_d    = 1'b0;
                    fidx_d    = '0;
                    state_d   = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_inc;
                    if (acc_inc == nsamp_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!vld_p1_q && !vld_p2_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            nsamp_q   <= '0;
            acc_cnt_q <= '0;
            viol_q    <= '0;
            max_q     <= '0;
            fvld_q    <= 1'b0;
            fidx_q    <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            nsamp_q   <= nsamp_d;
            acc_cnt_q <= acc_cnt_d;
            viol_q    <= viol_d;
            max_q     <= max_d;
            fvld_q    <= fvld_d;
            fidx_q    <= fidx_d;
            vld_p1_q  <= accept;
            vld_p2_q  <= vld_p1_q;
        end
    end

    // S1/S2 datapath: qualified by the valids above, so it needs no reset
    always_ff @(posedge clk) begin
        diff_p1_q <= a ^ b;
        idx_p1_q  <= acc_cnt_q;
        hd_p2_q   <= hd_p1;
        idx_p2_q  <= idx_p1_q;
    end

    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign viol_cnt       = viol_q;
    assign max_hd         = max_q;
    assign first_viol_vld = fvld_q;
    assign first_viol_idx = fidx_q;

endmodule

// File: tb/tb_mhd_err_monitor.sv
// Scoreboard bench for mhd_err_monitor: expected window stats are queued at start, checked on done.
module tb_mhd_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_s;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [32:0] a, b;

    logic        in_ready, busy, done, fvv;
    logic [15:0] viol_cnt, fvi;
    logic [5:0]  max_hd;

    logic        in_ready_s, busy_s, done_s, fvv_s;
    logic [1:0]  viol_cnt_s;
    logic [15:0] fvi_s;
    logic [5:0]  max_hd_s;

    mhd_err_monitor dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .busy(busy), .done(done), .viol_cnt(viol_cnt), .max_hd(max_hd),
        .first_viol_vld(fvv), .first_viol_idx(fvi)
    );

    mhd_err_monitor #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .viol_cnt(viol_cnt_s), .max_hd(max_hd_s),
        .first_viol_vld(fvv_s), .first_viol_idx(fvi_s)
    );

    always #5 clk = ~clk;

    typedef struct { int v; int m; int fv; int fi; } exp_t;
    exp_t q[$];
    exp_t qs[$];
    exp_t e, es;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic done_prev = 1'b0;
    logic done_s_prev = 1'b0;

    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                e = q.pop_front();
                chk("viol_cnt", 64'(viol_cnt), 64'(e.v));
                chk("max_hd", 64'(max_hd), 64'(e.m));
                chk("first_viol_vld", 64'(fvv), 64'(e.fv));
                chk("first_viol_idx", 64'(fvi), 64'(e.fi));
            end
        end
        done_prev <= done;
    end

    always @(negedge clk) begin
        if (done_s && !done_s_prev) begin
            if (qs.size() == 0) begin
                chk("unexpected_done_s", 64'(1), 64'(0));
            end else begin
                es = qs.pop_front();
                chk("s_viol_cnt", 64'(viol_cnt_s), 64'(es.v));
                chk("s_max_hd", 64'(max_hd_s), 64'(es.m));
                chk("s_first_viol_vld", 64'(fvv_s), 64'(es.fv));
                chk("s_first_viol_idx", 64'(fvi_s), 64'(es.fi));
            end
        end
        done_s_prev <= done_s;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit sel, input int ns);
        num_samples = 16'(ns);
        if (sel) start_s = 1'b1;
        else     start   = 1'b1;
        tick();
        start   = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic send(input logic [32:0] av, input logic [32:0] bv, input bit v);
        a        = av;
        b        = bv;
        in_valid = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int n = 0;
        while (!(sel ? done_s : done) && n < budget) begin
            tick();
            n++;
        end
        chk(sel ? "s_done_timeout" : "done_timeout", 64'(n >= budget), 64'(0));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] x, mask;
        rst = 1'b1; start = 1'b0; start_s = 1'b0; num_samples = '0;
        in_valid = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_viol_cnt", 64'(viol_cnt), 64'(0));
        chk("rst_max_hd", 64'(max_hd), 64'(0));
        chk("rst_fvv", 64'(fvv), 64'(0));
        chk("rst_fvi", 64'(fvi), 64'(0));
        rst = 1'b0;
        tick();

        // Window 1: HD 0, 8, 9, 33
        q.push_back('{2, 33, 1, 2});
        do_start(0, 4);
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_in_ready", 64'(in_ready), 64'(1));
        x = 33'h0_1234_5678; send(x, x, 1);
        x = 33'h1_ABCD_EF01; send(x, x ^ 33'h0_0000_00FF, 1);
        x = 33'h0_F0F0_F0F0; send(x, x ^ 33'h0_0000_01FF, 1);
        x = 33'h1_5555_AAAA; send(x, ~x, 1);
        chk("t1_ready_end", 64'(in_ready), 64'(0));
        wait_done(0, 20);

        // Window 2: sixteen pairs at exactly HD 8
        q.push_back('{0, 8, 0, 0});
        do_start(0, 16);
        for (int i = 0; i < 16; i++) begin
            x    = 33'(i * 32'h9E37_79B9);
            mask = 33'h0_0000_00FF << i;
            send(x, x ^ mask, 1);
        end
        wait_done(0, 20);

        // Window 3: valid toggling with poisoned bubbles, HD 10, 3, 12
        q.push_back('{2, 12, 1, 0});
        do_start(0, 3);
        x = 33'h1_0F0F_0F0F;
        send(x, x ^ 33'h0_0000_03FF, 1);
        send(33'h0, 33'h1_FFFF_FFFF, 0);
        send(x, x ^ 33'h0_0000_0007, 1);
        send(33'h0, 33'h1_FFFF_FFFF, 0);
        send(x, x ^ 33'h0_0000_0FFF, 1);
        chk("t3_ready_low", 64'(in_ready), 64'(0));
        chk("t3_viol_t1", 64'(viol_cnt), 64'(1));
        chk("t3_max_t1", 64'(max_hd), 64'(10));
        tick();
        chk("t3_viol_t2", 64'(viol_cnt), 64'(1));
        tick();
        chk("t3_viol_t3", 64'(viol_cnt), 64'(2));
        chk("t3_max_t3", 64'(max_hd), 64'(12));
        chk("t3_done_t3", 64'(done), 64'(0));
        wait_done(0, 20);

        // Reset mid-window, then a fresh window
        do_start(0, 4);
        send(33'h0, 33'h0_000F_FFFF, 1);
        send(33'h0, 33'h0_000F_FFFF, 1);
        tick();
        tick();
        chk("t5_pre_rst_viol", 64'(viol_cnt), 64'(2));
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'(0));
        chk("t5_rst_ready", 64'(in_ready), 64'(0));
        chk("t5_rst_viol", 64'(viol_cnt), 64'(0));
        chk("t5_rst_max", 64'(max_hd), 64'(0));
        chk("t5_rst_fvv", 64'(fvv), 64'(0));
        chk("t5_rst_done", 64'(done), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        q.push_back('{1, 9, 1, 1});
        do_start(0, 2);
        x = 33'h0_3C3C_3C3C;
        send(x, x ^ 33'h0_0000_0001, 1);
        send(x, x ^ 33'h0_0000_01FF, 1);
        wait_done(0, 20);

        // Empty window from DONE: stats clear and done holds
        do_start(0, 0);
        chk("t4a_done", 64'(done), 64'(1));
        chk("t4a_viol", 64'(viol_cnt), 64'(0));
        chk("t4a_max", 64'(max_hd), 64'(0));
        chk("t4a_fvv", 64'(fvv), 64'(0));
        chk("t4a_fvi", 64'(fvi), 64'(0));

        // Empty window from IDLE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        q.push_back('{0, 0, 0, 0});
        do_start(0, 0);
        chk("t4b_done", 64'(done), 64'(1));
        chk("t4b_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            chk("t4b_ready", 64'(in_ready), 64'(0));
            tick();
        end
        in_valid = 1'b0;

        // Saturating counter instance; start during RUN ignored
        qs.push_back('{3, 33, 1, 0});
        do_start(1, 6);
        x = 33'h1_5555_5555;
        send(x, ~x, 1);
        send(x, ~x, 1);
        start_s = 1'b1;
        num_samples = 16'd2;
        send(x, ~x, 1);
        start_s = 1'b0;
        chk("t6_busy_after_start", 64'(busy_s), 64'(1));
        chk("t6_ready_after_start", 64'(in_ready_s), 64'(1));
        send(x, ~x, 1);
        send(x, ~x, 1);
        send(x, ~x, 1);
        chk("t6_ready_end", 64'(in_ready_s), 64'(0));
        wait_done(1, 20);

        repeat (3) tick();
        chk("sb_empty", 64'(q.size()), 64'(0));
        chk("sb_s_empty", 64'(qs.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
